// File: rtl/alex_spi_tx.sv
// alex_spi_tx: serialises {HPF,LPF} into a 16-bit SPI frame with latch strobe for the Alex filter board (optional ALEX_PERIODIC_REFRESH_EN resends the word every 2^24 cycles)
module alex_spi_tx #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] HPF,
  input  logic [7:0] LPF,
  output logic       SPI_clock,
  output logic       SPI_data,
  output logic       SPI_load,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD, GAP} state_t;
  localparam logic [8:0] div_end  = 9'(CLK_DIV - 1);
  localparam logic [8:0] load_end = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] gap_end  = 9'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic [8:0] cnt, cnt_n;
  logic [3:0] bit_cnt, bit_n;
  logic [15:0] shift, shift_n, last_sent, last_n;
  logic force_send, force_n, start;
  logic [15:0] word;
  assign word = {HPF, LPF};
`ifdef ALEX_PERIODIC_REFRESH_EN
  logic [23:0] refresh, refresh_n;
`endif
  // state, counters and frame bookkeeping registers
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      last_sent  <= '0;
      force_send <= 1'b1;
`ifdef ALEX_PERIODIC_REFRESH_EN
      refresh    <= '0;
`endif
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      last_sent  <= last_n;
      force_send <= force_n;
`ifdef ALEX_PERIODIC_REFRESH_EN
      refresh    <= refresh_n;
`endif
    end
  end
  // next-state logic: phase timing, bit shifting and change detection
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 9'd1;
    bit_n   = bit_cnt;
    shift_n = shift;
    last_n  = last_sent;
    force_n = force_send;
    start   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (force_send || word != last_sent) begin
          state_n = SHIFT_LO;
          shift_n = word;
          last_n  = word;
          force_n = 1'b0;
          bit_n   = '0;
          start   = 1'b1;
        end
      end
      SHIFT_LO: if (cnt == div_end) begin
        cnt_n   = '0;
        state_n = SHIFT_HI;
      end
      SHIFT_HI: if (cnt == div_end) begin
        cnt_n   = '0;
        shift_n = {shift[14:0], 1'b0};
        bit_n   = bit_cnt + 4'd1;
        state_n = bit_cnt == 4'd15 ? LOAD : SHIFT_LO;
      end
      LOAD: if (cnt == load_end) begin
        cnt_n   = '0;
        state_n = GAP;
      end
      GAP: if (cnt == gap_end) begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
`ifdef ALEX_PERIODIC_REFRESH_EN
    refresh_n = start ? '0 : refresh + 24'd1;
    if (refresh == 24'hFFFFFF && !start) force_n = 1'b1;
`endif
  end
  assign SPI_clock = state == SHIFT_HI;
  assign SPI_data  = (state == SHIFT_LO || state == SHIFT_HI) && shift[15];
  assign SPI_load  = state == LOAD;
  assign busy      = state != IDLE;
  a_clk_div: assert property (@(posedge clock) CLK_DIV != 0);
endmodule

// File: tb/tb_alex_spi_tx.sv
// tb_alex_spi_tx: directed self-checking bench for alex_spi_tx
module tb_alex_spi_tx;
  logic clock = 0, reset_n = 0;
  logic [7:0] HPF = 8'h01, LPF = 8'h00;
  logic SPI_clock, SPI_data, SPI_load, busy;
  int n_cmp = 0, n_fail = 0;
  int nf, rises, load_cyc, busy_cyc, first_rise, rise_at, fall_at;
  logic [15:0] sh = '0;
  logic [15:0] words [4];

  alex_spi_tx dut (
    .clock(clock), .reset_n(reset_n), .HPF(HPF), .LPF(LPF),
    .SPI_clock(SPI_clock), .SPI_data(SPI_data), .SPI_load(SPI_load), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic watch(input int n);
    logic pc, pl, pb;
    pc = SPI_clock; pl = SPI_load; pb = busy;
    nf = 0; rises = 0; load_cyc = 0; busy_cyc = 0;
    first_rise = -1; rise_at = -1; fall_at = -1;
    for (int i = 1; i <= n; i++) begin
      @(posedge clock); #1;
      if (SPI_clock && !pc) begin
        sh = {sh[14:0], SPI_data};
        rises++;
        if (first_rise < 0) first_rise = i;
      end
      if (SPI_load && !pl && nf < 4) begin
        words[nf] = sh;
        nf++;
      end
      if (busy && !pb && rise_at < 0) rise_at = i;
      if (!busy && pb && fall_at < 0) fall_at = i;
      load_cyc += int'(SPI_load);
      busy_cyc += int'(busy);
      pc = SPI_clock; pl = SPI_load; pb = busy;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++; if (SPI_clock !== 1'b0) begin n_fail++; $display("FAIL reset_clk: got %b expected 0", SPI_clock); end
    n_cmp++; if (SPI_data !== 1'b0) begin n_fail++; $display("FAIL reset_data: got %b expected 0", SPI_data); end
    n_cmp++; if (SPI_load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b expected 0", SPI_load); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1;
    watch(300);
    n_cmp++; if (nf !== 1) begin n_fail++; $display("FAIL forced_frames: got %0d expected 1", nf); end
    n_cmp++; if (words[0] !== 16'h0100) begin n_fail++; $display("FAIL forced_word: got %h expected 0100", words[0]); end
    n_cmp++; if (rises !== 16) begin n_fail++; $display("FAIL forced_rises: got %0d expected 16", rises); end
    n_cmp++; if (load_cyc !== 8) begin n_fail++; $display("FAIL forced_load_len: got %0d expected 8", load_cyc); end
    n_cmp++; if (busy_cyc !== 144) begin n_fail++; $display("FAIL forced_busy_len: got %0d expected 144", busy_cyc); end
  endtask

  task automatic test_change;
    HPF = 8'h20;
    watch(200);
    n_cmp++; if (first_rise !== 5) begin n_fail++; $display("FAIL change_latency: got %0d expected 5", first_rise); end
    n_cmp++; if (nf !== 1) begin n_fail++; $display("FAIL change_frames: got %0d expected 1", nf); end
    n_cmp++; if (words[0] !== 16'h2000) begin n_fail++; $display("FAIL change_word: got %h expected 2000", words[0]); end
    n_cmp++; if (busy_cyc !== 144) begin n_fail++; $display("FAIL change_busy_len: got %0d expected 144", busy_cyc); end
  endtask

  task automatic test_midframe;
    HPF = 8'h01;
    watch(200);
    n_cmp++; if (words[0] !== 16'h0100) begin n_fail++; $display("FAIL pre_word: got %h expected 0100", words[0]); end
    HPF = 8'h20;
    watch(43);
    HPF = 8'h40;
    watch(3);
    HPF = 8'h80;
    watch(400);
    n_cmp++; if (nf !== 2) begin n_fail++; $display("FAIL mid_frames: got %0d expected 2", nf); end
    n_cmp++; if (words[0] !== 16'h2000) begin n_fail++; $display("FAIL mid_inflight_word: got %h expected 2000", words[0]); end
    n_cmp++; if (words[1] !== 16'h8000) begin n_fail++; $display("FAIL mid_followup_word: got %h expected 8000", words[1]); end
    n_cmp++; if (rise_at !== fall_at + 1) begin n_fail++; $display("FAIL mid_restart: got busy rise %0d expected %0d", rise_at, fall_at + 1); end
  endtask

  task automatic test_toggle;
    HPF = 8'h01;
    watch(20);
    HPF = 8'h02;
    watch(20);
    HPF = 8'h01;
    watch(200);
    n_cmp++; if (words[0] !== 16'h0100) begin n_fail++; $display("FAIL toggle_word: got %h expected 0100", words[0]); end
    watch(500);
    n_cmp++; if (rises !== 0) begin n_fail++; $display("FAIL toggle_rises: got %0d expected 0", rises); end
    n_cmp++; if (busy_cyc !== 0) begin n_fail++; $display("FAIL toggle_busy: got %0d expected 0", busy_cyc); end
  endtask

  task automatic test_reset_load;
    int t;
    HPF = 8'h04; LPF = 8'h5A;
    t = 0;
    while (!SPI_load && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    n_cmp++; if (SPI_load !== 1'b1) begin n_fail++; $display("FAIL load_reached: got %b expected 1", SPI_load); end
    reset_n = 0;
    @(posedge clock); #1;
    n_cmp++; if (SPI_load !== 1'b0) begin n_fail++; $display("FAIL abort_load: got %b expected 0", SPI_load); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if ({SPI_clock, SPI_data} !== 2'b00) begin n_fail++; $display("FAIL abort_serial: got %b expected 00", {SPI_clock, SPI_data}); end
    reset_n = 1;
    watch(300);
    n_cmp++; if (nf !== 1) begin n_fail++; $display("FAIL reforce_frames: got %0d expected 1", nf); end
    n_cmp++; if (words[0] !== 16'h045A) begin n_fail++; $display("FAIL reforce_word: got %h expected 045a", words[0]); end
    n_cmp++; if (load_cyc !== 8) begin n_fail++; $display("FAIL reforce_load_len: got %0d expected 8", load_cyc); end
  endtask

  initial begin
    test_reset;
    test_change;
    test_midframe;
    test_toggle;
    test_reset_load;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
